// File: rtl/wb_uart_pkg.sv
// rtl/wb_uart_pkg.sv - shared register map, STATUS bit indices and FSM encodings for wb_uart_lite
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_TX_BUSY      = 0;
  localparam int ST_RX_VALID     = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_RX_FRAME_ERR = 3;
  localparam int ST_LOOP         = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - down-counting bit timer, ticks at terminal count and reloads from the live divisor
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_load,
  input  logic             i_load_half,
  input  logic             i_run,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == '0);

  // Reloading from i_div at each tick makes a divisor change land on the next bit boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div - DIV_W'(1);
    end else if (i_load_half) begin
      r_cnt <= (i_div >> 1) - DIV_W'(1);
    end else if (o_tick) begin
      r_cnt <= i_div - DIV_W'(1);
    end else if (i_run) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/wb_uart_lite.sv
// rtl/wb_uart_lite.sv - Wishbone classic 8N1 UART; WB_UART_LOOPBACK_EN adds STATUS bit4 internal loopback
module wb_uart_lite
  import wb_uart_pkg::*;
#(
  parameter int CLK_DIV_RESET = 1042,
  parameter int DIV_W         = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        uart_tx,
  input  logic        uart_rx
);

  logic             r_ack;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       w_sel;
  logic             w_acc, w_wr, w_rd, w_data_rd, w_st_wr;
  logic [DIV_W-1:0] w_div_new;
  logic [31:0]      w_rd_data;
  logic             w_unused;

  logic [1:0] r_tx_state;
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_bit;
  logic       w_tx_busy, w_tx_start, w_tx_tick, w_tx_line;

  logic       r_rx_s1, r_rx_s2, r_rx_prev, r_rx_hold;
  logic [1:0] r_rx_state;
  logic [7:0] r_rx_shift, r_rx_data;
  logic [2:0] r_rx_bit;
  logic       r_rx_valid, r_rx_overrun, r_rx_ferr;
  logic       w_rx_in, w_rx_fall, w_rx_run, w_rx_tick, w_rx_done, w_rx_bad;

  assign w_unused  = ^{wb_adr_i[1:0], wb_sel_i, wb_dat_i};
  assign w_sel     = wb_adr_i[3:2];
  // Side effects happen in the ack cycle only, while the master still holds the request.
  assign w_acc     = r_ack && wb_cyc_i && wb_stb_i;
  assign w_wr      = w_acc && wb_we_i;
  assign w_rd      = w_acc && !wb_we_i;
  assign w_data_rd = w_rd && (w_sel == REG_DATA);
  assign w_st_wr   = w_wr && (w_sel == REG_STATUS);
  assign w_div_new = wb_dat_i[DIV_W-1:0];
  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_ack ? w_rd_data : 32'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_div <= DIV_W'(CLK_DIV_RESET);
    end else begin
      r_ack <= wb_cyc_i && wb_stb_i && !r_ack;
      if (w_wr && (w_sel == REG_DIV)) begin
        r_div <= (w_div_new < DIV_W'(2)) ? DIV_W'(2) : w_div_new;
      end
    end
  end

`ifdef WB_UART_LOOPBACK_EN
  logic r_loop;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_loop <= 1'b0;
    end else if (w_st_wr) begin
      r_loop <= wb_dat_i[ST_LOOP];
    end
  end
  assign w_rx_in = r_loop ? w_tx_line : uart_rx;
  assign uart_tx = r_loop ? 1'b1 : w_tx_line;
`else
  assign w_rx_in = uart_rx;
  assign uart_tx = w_tx_line;
`endif

  always_comb begin
    w_rd_data = 32'h0;
    case (w_sel)
      REG_DATA:   w_rd_data[7:0] = r_rx_data;
      REG_STATUS: begin
        w_rd_data[ST_TX_BUSY]      = w_tx_busy;
        w_rd_data[ST_RX_VALID]     = r_rx_valid;
        w_rd_data[ST_RX_OVERRUN]   = r_rx_overrun;
        w_rd_data[ST_RX_FRAME_ERR] = r_rx_ferr;
`ifdef WB_UART_LOOPBACK_EN
        w_rd_data[ST_LOOP]         = r_loop;
`else
        w_rd_data[ST_LOOP]         = 1'b0;
`endif
      end
      REG_DIV:    w_rd_data = 32'(r_div);
      REG_RSVD:   w_rd_data = 32'h0;
      default:    w_rd_data = 32'h0;
    endcase
  end

  // Transmitter
  assign w_tx_busy  = (r_tx_state != S_IDLE);
  assign w_tx_start = w_wr && (w_sel == REG_DATA) && !w_tx_busy;

  uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
    .clock       (clock),
    .reset       (reset),
    .i_div       (r_div),
    .i_load      (w_tx_start),
    .i_load_half (1'b0),
    .i_run       (w_tx_busy),
    .o_tick      (w_tx_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_shift <= 8'h0;
      r_tx_bit   <= 3'd0;
    end else begin
      case (r_tx_state)
        S_IDLE: if (w_tx_start) begin
          r_tx_shift <= wb_dat_i[7:0];
          r_tx_bit   <= 3'd0;
          r_tx_state <= S_START;
        end
        S_START: if (w_tx_tick) r_tx_state <= S_DATA;
        S_DATA: if (w_tx_tick) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) r_tx_state <= S_STOP;
        end
        S_STOP: if (w_tx_tick) r_tx_state <= S_IDLE;
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tx_line = 1'b1;
    case (r_tx_state)
      S_START: w_tx_line = 1'b0;
      S_DATA:  w_tx_line = r_tx_shift[0];
      default: w_tx_line = 1'b1;
    endcase
  end

  // Receiver
  assign w_rx_fall = r_rx_prev && !r_rx_s2;
  assign w_rx_run  = (r_rx_state != S_IDLE) && !r_rx_hold;
  assign w_rx_done = (r_rx_state == S_STOP) && w_rx_tick && r_rx_s2;
  assign w_rx_bad  = (r_rx_state == S_STOP) && w_rx_tick && !r_rx_s2;

  uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
    .clock       (clock),
    .reset       (reset),
    .i_div       (r_div),
    .i_load      (1'b0),
    .i_load_half ((r_rx_state == S_IDLE) && w_rx_fall),
    .i_run       (w_rx_run),
    .o_tick      (w_rx_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_shift <= 8'h0;
      r_rx_bit   <= 3'd0;
      r_rx_hold  <= 1'b0;
    end else begin
      r_rx_s1   <= w_rx_in;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        S_IDLE: if (w_rx_fall) begin
          r_rx_bit   <= 3'd0;
          r_rx_state <= S_START;
        end
        // A start bit that is high again at mid-bit was a glitch.
        S_START: if (w_rx_tick) r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
        S_DATA: if (w_rx_tick) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
        end
        S_STOP: begin
          if (r_rx_hold) begin
            if (r_rx_s2) begin
              r_rx_hold  <= 1'b0;
              r_rx_state <= S_IDLE;
            end
          end else if (w_rx_tick) begin
            if (r_rx_s2) r_rx_state <= S_IDLE;
            else         r_rx_hold  <= 1'b1;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_data    <= 8'h0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_ferr    <= 1'b0;
    end else begin
      if (w_rx_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_data_rd) begin
        r_rx_valid <= 1'b0;
      end
      if (w_st_wr && wb_dat_i[ST_RX_OVERRUN]) r_rx_overrun <= 1'b0;
      if (w_rx_done && r_rx_valid && !w_data_rd) r_rx_overrun <= 1'b1;
      if (w_st_wr && wb_dat_i[ST_RX_FRAME_ERR]) r_rx_ferr <= 1'b0;
      if (w_rx_bad) r_rx_ferr <= 1'b1;
    end
  end

endmodule
